// File: rtl/pipe_issue_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_issue_ctrl
//
// Issue controller for a fixed-latency, non-stallable datapath. Two
// valid/ready requesters are arbitrated round-robin onto the datapath input.
// A LATENCY-deep tag pipe carries {valid, id} alongside the datapath so that
// the datapath output can be captured, together with the requester id, into a
// first-word-fall-through result FIFO. A credit counter covers both in-flight
// and stored items, so an issued item always has a FIFO slot reserved and no
// result is lost when the consumer stalls.
//
// Parameters
//   DATA_W      width of request data, datapath input and datapath output
//   LATENCY     datapath cycles from pipe_in to pipe_out_data (>= 1)
//   FIFO_DEPTH  result FIFO entries, power of two (>= 2)
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   req0_valid/data/ready      requester 0 (ready = accepted this cycle)
//   req1_valid/data/ready      requester 1 (ready = accepted this cycle)
//   pipe_in_valid/data         issue strobe and payload to the datapath
//   pipe_out_data              datapath output, LATENCY cycles after issue
//   out_valid/ready/data/id    result FIFO head (first-word-fall-through)
//   credits                    free slots = FIFO_DEPTH - in flight - stored
//   busy                       any item in flight or stored
// ----------------------------------------------------------------------------
module pipe_issue_ctrl #(
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  input  logic [DATA_W-1:0]             req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [DATA_W-1:0]             req1_data,
  output logic                          req1_ready,
  output logic                          pipe_in_valid,
  output logic [DATA_W-1:0]             pipe_in_data,
  input  logic [DATA_W-1:0]             pipe_out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_id,
  output logic [$clog2(FIFO_DEPTH):0]   credits,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  logic               rr_q, rr_d;          // 1 = requester 1 favoured on conflict
  logic [CW-1:0]      credits_q, credits_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0] tag_id_q, tag_id_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  // FIFO storage holds {id, data}; it is never reset, occupancy is tracked
  // by the pointers and count.
  logic [DATA_W:0]    mem_q [FIFO_DEPTH];

  logic can_issue;
  logic grant0, grant1;
  logic issue;
  logic push, pop;

  // --------------------------------------------------------------------------
  // Arbitration and issue
  // --------------------------------------------------------------------------
  // Issue is gated by rst so no ready is shown while reset is held, even
  // though credits already read FIFO_DEPTH at that point.
  assign can_issue = (credits_q != '0) & ~rst;

  // With both valid, the favoured requester wins; a lone requester always wins.
  assign grant0 = req0_valid & (~req1_valid | ~rr_q);
  assign grant1 = req1_valid & ~grant0;

  assign req0_ready    = can_issue & grant0;
  assign req1_ready    = can_issue & grant1;
  assign issue         = req0_ready | req1_ready;
  assign pipe_in_valid = issue;

  always_comb begin
    pipe_in_data = '0;
    if (req0_ready) begin
      pipe_in_data = req0_data;
    end else if (req1_ready) begin
      pipe_in_data = req1_data;
    end
  end

  // After granting requester N the other one is favoured next time.
  assign rr_d = issue ? req0_ready : rr_q;

  // --------------------------------------------------------------------------
  // Tag pipe: shifts every cycle, mirroring the datapath delay line
  // --------------------------------------------------------------------------
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = issue;
    tag_id_d[0]  = req1_ready;
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // --------------------------------------------------------------------------
  // Result FIFO bookkeeping
  // --------------------------------------------------------------------------
  // The tag tail lines up with pipe_out_data in the same cycle.
  assign push = tag_vld_q[LATENCY-1];
  assign pop  = out_valid & out_ready;

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q][DATA_W-1:0];
  assign out_id    = mem_q[rd_ptr_q][DATA_W];

  // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Credits: reserved at issue, returned when the consumer pops
  // --------------------------------------------------------------------------
  always_comb begin
    case ({issue, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  assign credits = credits_q;
  assign busy    = (credits_q != CRED_MAX);

  // --------------------------------------------------------------------------
  // Control registers (asynchronous reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q      <= 1'b0;
      credits_q <= CRED_MAX;
      tag_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      rr_q      <= rr_d;
      credits_q <= credits_d;
      tag_vld_q <= tag_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Data registers (no reset; qualified by the control state above)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    tag_id_q <= tag_id_d;
    if (push) begin
      mem_q[wr_ptr_q] <= {tag_id_q[LATENCY-1], pipe_out_data};
    end
  end

  // A write into a full FIFO is impossible because every in-flight item
  // holds a credit; a simultaneous pop frees the slot being overwritten.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == CRED_MAX)));

  a_credit_range: assert property (@(posedge clk) disable iff (rst)
    (credits_q <= CRED_MAX));

endmodule
